// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data, occupancy count
// and sticky overflow/underflow flags for the monitor side.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   input  logic              pop,
   output logic              empty,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic [DATA_W-1:0] r_data_out;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_full;
   logic              w_empty;
   logic              w_push_ok;
   logic              w_pop_ok;
   logic              w_push_rej;
   logic              w_pop_rej;

   // Flags come only from registered pointers; the MSB is the wrap bit.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

   assign w_push_ok  = push && !w_full;
   assign w_pop_ok   = pop && !w_empty;
   assign w_push_rej = push && w_full;
   assign w_pop_rej  = pop && w_empty;

   // Storage is not reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
      end else if (w_push_ok) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_data_out <= '0;
      end else if (w_pop_ok) begin
         r_rd_ptr   <= r_rd_ptr + 1'b1;
         r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_rej) begin
            r_overflow <= 1'b1;
         end
         if (w_pop_rej) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign full      = w_full;
   assign empty     = w_empty;
   assign data_out  = r_data_out;
   assign count     = r_wr_ptr - r_rd_ptr;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule
